// File: rtl/bldc_commutation_ctrl.sv
// Six-step BLDC commutation sequencer: hall decode, dead time, duty ramp, hall/stall faults.
// Latency: a hall pin edge turns the gates off 3 clk later; the new pattern follows DEADTIME clk after that.
// Backpressure: none; duty_cycle feeds pwm_generator directly and every output is registered.
module bldc_commutation_ctrl #(
    parameter int RAMP_DIV     = 256,
    parameter int RAMP_STEP    = 1,
    parameter int DEADTIME     = 4,
    parameter int STALL_CYCLES = 2**20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       direction,
    input  logic [2:0] hall,
    input  logic [7:0] target_duty,
    output logic [7:0] duty_cycle,
    output logic [2:0] high_en,
    output logic [2:0] low_en,
    output logic       running,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam int SW = $clog2(STALL_CYCLES + 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(RAMP_DIV - 1);
    localparam logic [DW-1:0] DEAD_LAST  = DW'(DEADTIME - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYCLES - 1);
    localparam logic [8:0]    STEP9      = 9'(RAMP_STEP);

    typedef enum logic [2:0] {IDLE, DEAD, RUN, STOP, FAULT} state_t;

    state_t          state;
    logic [2:0]      hall_meta;
    logic [2:0]      hs;
    logic [2:0]      hs_prev;
    logic            dir_prev;
    logic [2:0]      pat_hs;
    logic            pat_dir;
    logic [PW-1:0]   pre;
    logic [DW-1:0]   dead_cnt;
    logic [SW-1:0]   stall_cnt;

    logic            hs_valid;
    logic            hs_chg;
    logic            dir_chg;
    logic            pat_chg;
    logic            active;
    logic            tick;
    logic            stall_hit;
    logic            flt;
    logic [1:0]      flt_code;
    logic [7:0]      eff_tgt;
    logic [8:0]      duty_up;
    logic [8:0]      duty_dn;
    logic [7:0]      nxt_duty;

    // {high_en, low_en} for forward rotation; reverse swaps the two halves.
    function automatic logic [5:0] decode(input logic [2:0] h, input logic rev);
        logic [5:0] p;
        case (h)
            3'b101:  p = {3'b001, 3'b010};
            3'b100:  p = {3'b001, 3'b100};
            3'b110:  p = {3'b010, 3'b100};
            3'b010:  p = {3'b010, 3'b001};
            3'b011:  p = {3'b100, 3'b001};
            3'b001:  p = {3'b100, 3'b010};
            default: p = 6'b000000;
        endcase
        return rev ? {p[2:0], p[5:3]} : p;
    endfunction

    always_ff @(posedge clk) begin
        hall_meta <= hall;
        hs        <= hall_meta;
        hs_prev   <= hs;
        dir_prev  <= direction;
    end

    always_comb begin
        hs_valid  = (hs != 3'b000) && (hs != 3'b111);
        hs_chg    = (hs != hs_prev);
        dir_chg   = (direction != dir_prev);
        pat_chg   = (hs != pat_hs) || (direction != pat_dir);
        active    = (state == DEAD) || (state == RUN) || (state == STOP);
        tick      = active && (pre == PRE_LAST);
        stall_hit = (stall_cnt == STALL_LAST) && (duty_cycle != 8'd0) && !hs_chg;
        flt       = active && (!hs_valid || stall_hit);
        flt_code  = !hs_valid ? 2'b01 : 2'b10;
        eff_tgt   = (state == STOP) ? 8'd0 : target_duty;
    end

    // 9-bit slew so neither the step up past 255 nor the step down past 0 can wrap.
    always_comb begin
        duty_up  = {1'b0, duty_cycle} + STEP9;
        duty_dn  = {1'b0, duty_cycle} - STEP9;
        nxt_duty = duty_cycle;
        if (tick) begin
            if (duty_cycle < eff_tgt)
                nxt_duty = (duty_up > {1'b0, eff_tgt}) ? eff_tgt : duty_up[7:0];
            else if (duty_cycle > eff_tgt)
                nxt_duty = (duty_dn[8] || (duty_dn[7:0] < eff_tgt)) ? eff_tgt : duty_dn[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !active)
            pre <= '0;
        else
            pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;

        if (reset || !active || (duty_cycle == 8'd0) || hs_chg)
            stall_cnt <= '0;
        else
            stall_cnt <= stall_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            duty_cycle <= 8'd0;
            high_en    <= 3'b000;
            low_en     <= 3'b000;
            running    <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            dead_cnt   <= '0;
            pat_hs     <= 3'b000;
            pat_dir    <= 1'b0;
        end else begin
            running <= 1'b0;
            if (flt) begin
                state      <= FAULT;
                duty_cycle <= 8'd0;
                high_en    <= 3'b000;
                low_en     <= 3'b000;
                fault      <= 1'b1;
                fault_code <= flt_code;
            end else begin
                case (state)
                    IDLE: begin
                        high_en    <= 3'b000;
                        low_en     <= 3'b000;
                        duty_cycle <= 8'd0;
                        dead_cnt   <= '0;
                        if (enable && hs_valid) begin
                            state <= DEAD;
                        end else if (enable) begin
                            state      <= FAULT;
                            fault      <= 1'b1;
                            fault_code <= 2'b01;
                        end
                    end
                    DEAD: begin
                        duty_cycle <= nxt_duty;
                        high_en    <= 3'b000;
                        low_en     <= 3'b000;
                        if (hs_chg || dir_chg) begin
                            dead_cnt <= '0;
                        end else if (dead_cnt == DEAD_LAST) begin
                            pat_hs            <= hs;
                            pat_dir           <= direction;
                            {high_en, low_en} <= decode(hs, direction);
                            state             <= enable ? RUN : STOP;
                            running           <= enable && (nxt_duty == target_duty);
                        end else begin
                            dead_cnt <= dead_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        duty_cycle <= nxt_duty;
                        if (!enable) begin
                            state <= STOP;
                        end else if (pat_chg) begin
                            state    <= DEAD;
                            dead_cnt <= '0;
                            high_en  <= 3'b000;
                            low_en   <= 3'b000;
                        end else begin
                            running <= (nxt_duty == target_duty);
                        end
                    end
                    STOP: begin
                        duty_cycle <= nxt_duty;
                        if (duty_cycle == 8'd0) begin
                            state   <= IDLE;
                            high_en <= 3'b000;
                            low_en  <= 3'b000;
                        end else if (pat_chg) begin
                            state    <= DEAD;
                            dead_cnt <= '0;
                            high_en  <= 3'b000;
                            low_en   <= 3'b000;
                        end else if (enable) begin
                            state <= RUN;
                        end
                    end
                    FAULT: begin
                        duty_cycle <= 8'd0;
                        high_en    <= 3'b000;
                        low_en     <= 3'b000;
                        if (!enable) begin
                            state      <= IDLE;
                            fault      <= 1'b0;
                            fault_code <= 2'b00;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// Directed bench for bldc_commutation_ctrl: commutation table, dead time, ramp clamping, faults, reset.
module tb_bldc_commutation_ctrl;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       direction;
    logic [2:0] hall;
    logic [7:0] target_duty;
    logic [7:0] duty_cycle;
    logic [2:0] high_en;
    logic [2:0] low_en;
    logic       running;
    logic       fault;
    logic [1:0] fault_code;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] t2_hall [6];
    logic [2:0] t2_hi   [6];
    logic [2:0] t2_lo   [6];

    bldc_commutation_ctrl #(
        .RAMP_DIV(4), .RAMP_STEP(10), .DEADTIME(4), .STALL_CYCLES(1000)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .direction(direction),
        .hall(hall), .target_duty(target_duty), .duty_cycle(duty_cycle),
        .high_en(high_en), .low_en(low_en), .running(running),
        .fault(fault), .fault_code(fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clocks, sampling 1 time unit after each edge; gate legality is checked every cycle.
    task automatic step(input int n);
        bit legal;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            legal = ((high_en & low_en) == 3'b000) && ($countones(high_en) <= 1) &&
                    ($countones(low_en) <= 1) && ($countones(high_en) == $countones(low_en));
            chk("gate_legal", int'(legal), 1);
        end
    endtask

    task automatic ramp_to(input int goal, input int budget, input string tag);
        int prev;
        int cur;
        int n;
        bit bad;
        prev = int'(duty_cycle);
        n    = 0;
        bad  = 1'b0;
        while (int'(duty_cycle) != goal && n < budget) begin
            step(1);
            n++;
            cur = int'(duty_cycle);
            if (cur != prev) begin
                if (goal > prev) begin
                    if (!(cur == goal || (cur == prev + 10 && cur < goal))) bad = 1'b1;
                end else begin
                    if (!(cur == goal || (cur == prev - 10 && cur > goal))) bad = 1'b1;
                end
                prev = cur;
            end
        end
        chk({tag, "_reach"}, int'(duty_cycle), goal);
        chk({tag, "_steps"}, int'(bad), 0);
    endtask

    initial begin
        t2_hall = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
        t2_hi   = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
        t2_lo   = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b010, 3'b010};

        reset = 1'b1; enable = 1'b0; direction = 1'b0; hall = 3'b101; target_duty = 8'd0;
        step(4);
        reset = 1'b0;
        step(1);
        chk("rst_duty", int'(duty_cycle), 0);
        chk("rst_hi", int'(high_en), 0);
        chk("rst_lo", int'(low_en), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_code", int'(fault_code), 0);

        // Start-up: dead time from IDLE, then 10 per 4 clk up to 100.
        enable = 1'b1; target_duty = 8'd100;
        step(4);
        chk("t1_dead_hi", int'(high_en), 0);
        step(1);
        chk("t1_hi", int'(high_en), 3'b001);
        chk("t1_lo", int'(low_en), 3'b010);
        chk("t1_duty_first", int'(duty_cycle), 10);
        step(35);
        chk("t1_duty_90", int'(duty_cycle), 90);
        chk("t1_not_running", int'(running), 0);
        step(1);
        chk("t1_duty_100", int'(duty_cycle), 100);
        chk("t1_running", int'(running), 1);
        step(8);
        chk("t1_duty_hold", int'(duty_cycle), 100);

        // Forward rotation: gates off on the 3rd edge, new pattern 4 edges later.
        for (int i = 0; i < 6; i++) begin
            hall = t2_hall[i];
            step(3);
            chk($sformatf("t2_off_hi_%0d", i), int'(high_en), 0);
            chk($sformatf("t2_off_lo_%0d", i), int'(low_en), 0);
            step(3);
            chk($sformatf("t2_dead_hi_%0d", i), int'(high_en), 0);
            step(1);
            chk($sformatf("t2_hi_%0d", i), int'(high_en), int'(t2_hi[i]));
            chk($sformatf("t2_lo_%0d", i), int'(low_en), int'(t2_lo[i]));
            step(43);
        end

        // Reverse at hall 101 swaps high and low.
        direction = 1'b1;
        step(1);
        chk("t3_off_hi", int'(high_en), 0);
        step(3);
        chk("t3_dead_hi", int'(high_en), 0);
        step(1);
        chk("t3_rev_hi", int'(high_en), 3'b010);
        chk("t3_rev_lo", int'(low_en), 3'b001);
        step(10);
        direction = 1'b0;
        step(5);
        chk("t3_fwd_hi", int'(high_en), 3'b001);
        chk("t3_fwd_lo", int'(low_en), 3'b010);
        step(10);

        // Ramp to 250, clamp at 255, then stop: 255 down to 5, clamped to 0, then IDLE.
        target_duty = 8'd250;
        ramp_to(250, 100, "t4_up250");
        chk("t4_running", int'(running), 1);
        target_duty = 8'd255;
        ramp_to(255, 12, "t4_clamp255");
        enable = 1'b0;
        ramp_to(0, 150, "t4_down0");
        chk("t4_stop_hi", int'(high_en), 3'b001);
        step(1);
        chk("t4_idle_hi", int'(high_en), 0);
        chk("t4_idle_lo", int'(low_en), 0);
        chk("t4_idle_running", int'(running), 0);

        // Invalid hall while running.
        enable = 1'b1; target_duty = 8'd100;
        step(5);
        chk("t5_run_hi", int'(high_en), 3'b001);
        hall = 3'b111;
        step(2);
        chk("t5_pre_fault", int'(fault), 0);
        step(1);
        chk("t5_fault", int'(fault), 1);
        chk("t5_code", int'(fault_code), 1);
        chk("t5_hi", int'(high_en), 0);
        chk("t5_lo", int'(low_en), 0);
        chk("t5_duty", int'(duty_cycle), 0);
        hall = 3'b101;
        step(10);
        chk("t5_held", int'(fault), 1);
        chk("t5_held_code", int'(fault_code), 1);
        enable = 1'b0;
        step(1);
        chk("t5_clear", int'(fault), 0);
        chk("t5_clear_code", int'(fault_code), 0);

        // Stall: last hs change clears the counter on edge 3; fault lands on edge 1003.
        enable = 1'b1; target_duty = 8'd50;
        step(40);
        chk("t6_duty50", int'(duty_cycle), 50);
        chk("t6_running", int'(running), 1);
        hall = 3'b100;
        step(1002);
        chk("t6_no_fault_yet", int'(fault), 0);
        step(1);
        chk("t6_stall", int'(fault), 1);
        chk("t6_stall_code", int'(fault_code), 2);
        chk("t6_stall_duty", int'(duty_cycle), 0);
        chk("t6_stall_hi", int'(high_en), 0);
        enable = 1'b0;
        step(1);
        chk("t6_clear", int'(fault), 0);

        // Same again, but a hall edge at cycle 999 clears the counter just in time.
        enable = 1'b1;
        step(40);
        chk("t6b_duty50", int'(duty_cycle), 50);
        hall = 3'b110;
        step(999);
        hall = 3'b010;
        step(4);
        chk("t6b_no_fault", int'(fault), 0);
        step(20);
        chk("t6b_still_ok", int'(fault), 0);
        chk("t6b_hi", int'(high_en), 3'b010);
        chk("t6b_lo", int'(low_en), 3'b001);

        // Reset in RUN clears everything on the next edge.
        reset = 1'b1;
        step(1);
        chk("rst2_duty", int'(duty_cycle), 0);
        chk("rst2_hi", int'(high_en), 0);
        chk("rst2_lo", int'(low_en), 0);
        chk("rst2_running", int'(running), 0);
        chk("rst2_fault", int'(fault), 0);
        chk("rst2_code", int'(fault_code), 0);
        reset = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
